// File: rtl/conv_via_tiling_acc_32s.sv
// Accumulate stage of the conv_via_tiling MAC datapath: sums num_terms signed
// products onto a bias, applies optional ReLU, and hands one result per job downstream.
module conv_via_tiling_acc_32s #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_terms,
    input  logic [DATA_W-1:0] bias,
    input  logic              relu_en,
    output logic              busy,
    input  logic              prod_valid,
    input  logic [DATA_W-1:0] prod_data,
    output logic              prod_ready,
    output logic              sum_valid,
    output logic [DATA_W-1:0] sum_data,
    input  logic              sum_ready
);

    // state | meaning
    // IDLE  | waiting for start; sum_data keeps the last result
    // ACC   | taking product beats, one per cycle when prod_valid
    // OUT   | result presented, held until sum_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_num_terms;
    logic                r_relu;
    logic [DATA_W-1:0]   r_sum;

    logic                w_start_ok;
    logic                w_beat;
    logic                w_last;
    logic [DATA_W-1:0]   w_acc_sum;

    function automatic logic [DATA_W-1:0] relu_f(input logic en, input logic [DATA_W-1:0] x);
        return (en && x[DATA_W-1]) ? '0 : x;
    endfunction

    assign w_start_ok = (r_state == IDLE) && start;
    assign w_beat     = (r_state == ACC) && prod_valid;
    assign w_last     = w_beat && (r_cnt == (r_num_terms - CNT_W'(1)));
    assign w_acc_sum  = r_acc + prod_data;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (num_terms != '0) ? ACC : OUT;
                end
            end
            ACC: begin
                if (w_last) begin
                    w_state_nxt = OUT;
                end
            end
            OUT: begin
                if (sum_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_num_terms <= '0;
            r_relu      <= 1'b0;
            r_sum       <= '0;
        end else if (w_start_ok) begin
            r_acc       <= bias;
            r_cnt       <= '0;
            r_num_terms <= num_terms;
            r_relu      <= relu_en;
            // Zero-term job: the result is the bias itself, relu from the live input
            if (num_terms == '0) begin
                r_sum <= relu_f(relu_en, bias);
            end
        end else if (w_beat) begin
            r_acc <= w_acc_sum;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_sum <= relu_f(r_relu, w_acc_sum);
            end
        end
    end

    assign busy       = (r_state != IDLE);
    assign prod_ready = (r_state == ACC);
    assign sum_valid  = (r_state == OUT);
    assign sum_data   = r_sum;

endmodule
